// File: rtl/univ_counter.sv
// Parametrised universal up/down counter slice with load, modulus wrap and active-low ripple carry.
// Optional sticky wrap flag `ovf` is built only when UNIV_COUNTER_OVF_EN is defined.
module univ_counter #(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d,
    input  logic             nCryIn,
    output logic [WIDTH-1:0] q,
    output logic             nCryOut
`ifdef UNIV_COUNTER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [1:0] SEL_LOAD = 2'd0;
    localparam logic [1:0] SEL_DEC  = 2'd1;
    localparam logic [1:0] SEL_INC  = 2'd2;

    // Largest value in the count sequence; MODULUS of 0 means the natural 2**WIDTH wrap.
    localparam logic [WIDTH-1:0] TOP = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             ci;
    logic             co;
    logic             at_top;
    logic             at_zero;

    assign ci      = ~nCryIn;
    assign at_top  = (q_reg >= TOP);
    assign at_zero = (q_reg == '0);

    // Carry depends only on the current value, mode and carry-in, never on d or q_next.
    always_comb begin
        q_next = q_reg;
        co     = 1'b0;
        case (sel)
            SEL_LOAD: begin
                q_next = d;
                co     = 1'b1;
            end
            SEL_DEC: begin
                co = ci & at_zero;
                if (ci) begin
                    q_next = at_zero ? TOP : (q_reg - WIDTH'(1'b1));
                end
            end
            SEL_INC: begin
                co = ci & at_top;
                if (ci) begin
                    q_next = at_top ? '0 : (q_reg + WIDTH'(1'b1));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q       = q_reg;
    assign nCryOut = reset | ~co;

`ifdef UNIV_COUNTER_OVF_EN
    logic ovf_reg;
    logic ovf_next;
    logic wrap;

    // A wrap is a carry/borrow while counting; LOAD also asserts co but is not a wrap.
    assign wrap = co & (sel == SEL_INC || sel == SEL_DEC);

    always_comb begin
        ovf_next = ovf_reg;
        if (sel == SEL_LOAD) begin
            ovf_next = 1'b0;
        end else if (wrap) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_univ_counter.sv
// Scoreboard bench for univ_counter: four configurations (8-bit natural, decade, two-slice cascade, 3-bit)
// driven from shared stimulus and checked against an arithmetic reference model.
module tb_univ_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       nCryIn;
    logic [7:0] d8, dc;
    logic [3:0] d4;
    logic [2:0] d3;

    logic [7:0] q8;
    logic [3:0] q10, qlo, qhi;
    logic [2:0] q3;
    logic       n8, n10, nlo, nhi, n3;
    logic       ov8, ov10, ovlo, ovhi, ov3;

    always #5 clk = ~clk;

`ifdef UNIV_COUNTER_OVF_EN
    univ_counter #(.WIDTH(8), .MODULUS(0))  u8  (.clk(clk), .reset(reset), .sel(sel), .d(d8), .nCryIn(nCryIn), .q(q8),  .nCryOut(n8),  .ovf(ov8));
    univ_counter #(.WIDTH(4), .MODULUS(10)) u10 (.clk(clk), .reset(reset), .sel(sel), .d(d4), .nCryIn(nCryIn), .q(q10), .nCryOut(n10), .ovf(ov10));
    univ_counter #(.WIDTH(4), .MODULUS(0))  ulo (.clk(clk), .reset(reset), .sel(sel), .d(dc[3:0]), .nCryIn(nCryIn), .q(qlo), .nCryOut(nlo), .ovf(ovlo));
    univ_counter #(.WIDTH(4), .MODULUS(0))  uhi (.clk(clk), .reset(reset), .sel(sel), .d(dc[7:4]), .nCryIn(nlo), .q(qhi), .nCryOut(nhi), .ovf(ovhi));
    univ_counter #(.WIDTH(3), .MODULUS(0))  u3  (.clk(clk), .reset(reset), .sel(sel), .d(d3), .nCryIn(nCryIn), .q(q3),  .nCryOut(n3),  .ovf(ov3));
`else
    univ_counter #(.WIDTH(8), .MODULUS(0))  u8  (.clk(clk), .reset(reset), .sel(sel), .d(d8), .nCryIn(nCryIn), .q(q8),  .nCryOut(n8));
    univ_counter #(.WIDTH(4), .MODULUS(10)) u10 (.clk(clk), .reset(reset), .sel(sel), .d(d4), .nCryIn(nCryIn), .q(q10), .nCryOut(n10));
    univ_counter #(.WIDTH(4), .MODULUS(0))  ulo (.clk(clk), .reset(reset), .sel(sel), .d(dc[3:0]), .nCryIn(nCryIn), .q(qlo), .nCryOut(nlo));
    univ_counter #(.WIDTH(4), .MODULUS(0))  uhi (.clk(clk), .reset(reset), .sel(sel), .d(dc[7:4]), .nCryIn(nlo), .q(qhi), .nCryOut(nhi));
    univ_counter #(.WIDTH(3), .MODULUS(0))  u3  (.clk(clk), .reset(reset), .sel(sel), .d(d3), .nCryIn(nCryIn), .q(q3),  .nCryOut(n3));
    assign ov8 = 1'b0; assign ov10 = 1'b0; assign ovlo = 1'b0; assign ovhi = 1'b0; assign ov3 = 1'b0;
`endif

    typedef struct {
        int q8, n8, q10, n10, qc, nlo, nhi, q3, n3, ov3;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   txn   = 0;

    // Reference state: plain integers, the cascade modelled as one 8-bit number.
    int m8, m10, mc, m3, mov;

    function automatic int next_val(int v, int top, int s, bit ci, int dv, bit r);
        if (r) return 0;
        case (s)
            0: return dv;
            1: return ci ? ((v == 0) ? top : v - 1) : v;
            2: return ci ? ((v >= top) ? 0 : v + 1) : v;
            default: return v;
        endcase
    endfunction

    function automatic int ncry(int v, int top, int s, bit ci, bit r);
        bit co;
        case (s)
            0: co = 1'b1;
            1: co = ci && (v == 0);
            2: co = ci && (v >= top);
            default: co = 1'b0;
        endcase
        return (r || !co) ? 1 : 0;
    endfunction

    task automatic drive(input bit r, input int s, input bit nci, input int dv);
        exp_t e;
        bit   ci;
        @(negedge clk);
        reset  = r;
        sel    = 2'(s);
        nCryIn = nci;
        d8     = dv[7:0];
        dc     = dv[7:0];
        d4     = dv[3:0];
        d3     = dv[2:0];
        ci     = !nci;

        e.q8  = m8;  e.n8  = ncry(m8, 255, s, ci, r);
        e.q10 = m10; e.n10 = ncry(m10, 9, s, ci, r);
        e.q3  = m3;  e.n3  = ncry(m3, 7, s, ci, r);
        e.ov3 = mov;
        e.qc  = mc;
        if (r)           begin e.nlo = 1; e.nhi = 1; end
        else if (s == 0) begin e.nlo = 0; e.nhi = 0; end
        else if (s == 1) begin e.nlo = (ci && (mc % 16) == 0)  ? 0 : 1; e.nhi = (ci && mc == 0)   ? 0 : 1; end
        else if (s == 2) begin e.nlo = (ci && (mc % 16) == 15) ? 0 : 1; e.nhi = (ci && mc == 255) ? 0 : 1; end
        else             begin e.nlo = 1; e.nhi = 1; end
        sbq.push_back(e);

        if (r || s == 0)                      mov = 0;
        else if ((s == 1 || s == 2) && !e.n3) mov = 1;
        m8  = next_val(m8, 255, s, ci, dv % 256, r);
        m10 = next_val(m10, 9, s, ci, dv % 16, r);
        m3  = next_val(m3, 7, s, ci, dv % 8, r);
        if (r)                 mc = 0;
        else if (s == 0)       mc = dv % 256;
        else if (s == 1 && ci) mc = (mc + 255) % 256;
        else if (s == 2 && ci) mc = (mc + 1) % 256;
    endtask

    task automatic chk(input string nm, input int t, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL txn %0d %s: got %0h expected %0h", t, nm, act, exp);
        end
    endtask

    // Monitor: every cycle the DUTs present q and nCryOut; pop and compare once inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("q8",   txn, 36'(q8),  36'(e.q8));
                chk("n8",   txn, 36'(n8),  36'(e.n8));
                chk("q10",  txn, 36'(q10), 36'(e.q10));
                chk("n10",  txn, 36'(n10), 36'(e.n10));
                chk("qcas", txn, 36'({qhi, qlo}), 36'(e.qc));
                chk("nlo",  txn, 36'(nlo), 36'(e.nlo));
                chk("nhi",  txn, 36'(nhi), 36'(e.nhi));
                chk("q3",   txn, 36'(q3),  36'(e.q3));
                chk("n3",   txn, 36'(n3),  36'(e.n3));
`ifdef UNIV_COUNTER_OVF_EN
                chk("ovf3", txn, 36'(ov3), 36'(e.ov3));
`endif
                $display("[TB] txn %0d sel=%0d rst=%0b nci=%0b q8=%0d q10=%0d qc=%0h q3=%0d",
                         txn, sel, reset, nCryIn, q8, q10, {qhi, qlo}, q3);
                txn++;
            end
        end
    end

    initial begin
        reset = 1'b1; sel = 2'd3; nCryIn = 1'b1; d8 = '0; dc = '0; d4 = '0; d3 = '0;
        repeat (2) @(posedge clk);
        m8 = 0; m10 = 0; mc = 0; m3 = 0; mov = 0;

        // Reset state; borrow conditions present but nCryOut forced high.
        drive(1, 1, 0, 0);
        drive(1, 2, 0, 0);
        // Full 8-bit sweep and wrap (also wraps decade, cascade, 3-bit, sets ovf).
        for (int i = 0; i < 258; i++) drive(0, 2, 0, 0);
        // Decade: LOAD 7, INC x3 through 9 -> 0, DEC from 0 -> 9.
        drive(0, 0, 0, 7);
        for (int i = 0; i < 3; i++) drive(0, 2, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        // Out-of-range load: 13 >= TOP, next INC wraps to 0.
        drive(0, 0, 1, 13);
        drive(0, 2, 0, 0);
        drive(0, 3, 0, 0);
        // Cascade 0x0F -> 0x10 -> 0x0F, then HOLD.
        drive(0, 0, 0, 8'h0F);
        drive(0, 2, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 3, 0, 0);
        drive(0, 3, 0, 0);
        // Reset wins over INC; INC with nCryIn high holds.
        drive(0, 0, 0, 5);
        drive(1, 2, 0, 0);
        drive(0, 0, 0, 5);
        drive(0, 2, 1, 0);
        drive(0, 2, 1, 0);
        // Sticky wrap: INC from 7, more INC/HOLD, LOAD 2 clears.
        drive(0, 0, 0, 7);
        drive(0, 2, 0, 0);
        drive(0, 2, 0, 0);
        drive(0, 3, 0, 0);
        drive(0, 0, 0, 2);
        drive(0, 3, 0, 0);
        // Randomised mix.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)));
        end
        drive(0, 3, 1, 0);
        repeat (3) @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: got %0d entries left expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
